// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: writeback, read, reserve and debug signals.
// The master side drives requests and the slave side (the register file) responds.
interface regfile_mp_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NWRITE-1:0]      we_i;
  logic [NWRITE*AW-1:0]   waddr_i;
  logic [NWRITE*XLEN-1:0] wdata_i;
  logic [NREAD*AW-1:0]    raddr_i;
  logic [NREAD*XLEN-1:0]  rdata_o;
  logic [NREAD-1:0]       rbusy_o;
  logic                   rsv_i;
  logic [AW-1:0]          rsv_addr_i;
  logic [DEPTH-1:0]       busy_o;
  logic                   dbg_req_i;
  logic                   dbg_we_i;
  logic [AW-1:0]          dbg_addr_i;
  logic [XLEN-1:0]        dbg_wdata_i;
  logic                   dbg_gnt_o;
  logic                   dbg_rvalid_o;
  logic [XLEN-1:0]        dbg_rdata_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, rsv_i, rsv_addr_i,
           dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  rdata_o, rbusy_o, busy_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, rsv_i, rsv_addr_i,
           dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output rdata_o, rbusy_o, busy_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and a handshaked debug port.
// Reads are combinational (optionally write-first bypassed); writes, busy and debug response are registered.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  regfile_mp_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_RESP} state_e;

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  state_e           state_q, state_d;
  logic             rvalid_q, rvalid_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;

  logic [AW-1:0]    rd_addr [NREAD];
  logic [XLEN-1:0]  rd_data [NREAD];
  logic             rd_busy [NREAD];
  logic [AW-1:0]    wr_addr [NWRITE];
  logic             gnt_c;
  logic             dbg_zero_c;

  // Debug only slips in on cycles with no pipeline write or reservation.
  assign gnt_c      = (state_q == S_IDLE) && bus.dbg_req_i && !(|bus.we_i) && !bus.rsv_i;
  assign dbg_zero_c = ZERO_REG && (bus.dbg_addr_i == AW'(0));

  always_comb begin
    for (int w = 0; w < NWRITE; w++) begin
      wr_addr[w] = bus.waddr_i[w*AW +: AW];
    end
  end

  // Read ports: zero register beats bypass beats stored value; highest write port wins the bypass.
  always_comb begin
    for (int r = 0; r < NREAD; r++) begin
      rd_addr[r] = bus.raddr_i[r*AW +: AW];
      rd_data[r] = regs_q[rd_addr[r]];
      rd_busy[r] = busy_q[rd_addr[r]];
      if (BYPASS) begin
        for (int w = 0; w < NWRITE; w++) begin
          if (bus.we_i[w] && (wr_addr[w] == rd_addr[r])) begin
            rd_data[r] = bus.wdata_i[w*XLEN +: XLEN];
            rd_busy[r] = 1'b0;
          end
        end
      end
      if (ZERO_REG && (rd_addr[r] == AW'(0))) begin
        rd_data[r] = '0;
        rd_busy[r] = 1'b0;
      end
      bus.rdata_o[r*XLEN +: XLEN] = rd_data[r];
      bus.rbusy_o[r]              = rd_busy[r];
    end
  end

  // Storage and scoreboard update; a reservation overrides a same-cycle clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NWRITE; w++) begin
      if (bus.we_i[w]) begin
        if (!(ZERO_REG && (wr_addr[w] == AW'(0)))) begin
          regs_d[wr_addr[w]] = bus.wdata_i[w*XLEN +: XLEN];
        end
        busy_d[wr_addr[w]] = 1'b0;
      end
    end
    if (gnt_c && bus.dbg_we_i) begin
      if (!dbg_zero_c) begin
        regs_d[bus.dbg_addr_i] = bus.dbg_wdata_i;
      end
      busy_d[bus.dbg_addr_i] = 1'b0;
    end
    if (bus.rsv_i && !(ZERO_REG && (bus.rsv_addr_i == AW'(0)))) begin
      busy_d[bus.rsv_addr_i] = 1'b1;
    end
  end

  // Debug FSM: a granted read spends exactly one cycle in RESP presenting the response.
  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_c && !bus.dbg_we_i) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = dbg_zero_c ? '0 : regs_q[bus.dbg_addr_i];
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= '0;
      state_q  <= S_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q   <= busy_d;
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.dbg_gnt_o    = gnt_c;
  assign bus.dbg_rvalid_o = rvalid_q;
  assign bus.dbg_rdata_o  = rdata_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a two-write-port bypassing instance plus a
// single-write-port non-bypassing instance for write-to-read latency.
module tb_regfile_mp;
  logic clk_i = 1'b0;
  logic rstn_i;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  regfile_mp_if #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2)) a_if ();
  regfile_mp_if #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(1)) b_if ();

  regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk_i(clk_i), .rstn_i(rstn_i), .bus(a_if.slave));
  regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(1), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk_i(clk_i), .rstn_i(rstn_i), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.we_i = '0; a_if.waddr_i = '0; a_if.wdata_i = '0; a_if.raddr_i = '0;
    a_if.rsv_i = 1'b0; a_if.rsv_addr_i = '0;
    a_if.dbg_req_i = 1'b0; a_if.dbg_we_i = 1'b0; a_if.dbg_addr_i = '0; a_if.dbg_wdata_i = '0;
    b_if.we_i = '0; b_if.waddr_i = '0; b_if.wdata_i = '0; b_if.raddr_i = '0;
    b_if.rsv_i = 1'b0; b_if.rsv_addr_i = '0;
    b_if.dbg_req_i = 1'b0; b_if.dbg_we_i = 1'b0; b_if.dbg_addr_i = '0; b_if.dbg_wdata_i = '0;
  endtask

  initial begin
    idle_inputs();
    rstn_i = 1'b0;
    #12;
    chk("rst_busy", 64'(a_if.busy_o), 64'h0);
    chk("rst_rvalid", 64'(a_if.dbg_rvalid_o), 64'h0);
    chk("rst_rdata_dbg", 64'(a_if.dbg_rdata_o), 64'h0);
    chk("rst_rd0", 64'(a_if.rdata_o[31:0]), 64'h0);
    tick();
    rstn_i = 1'b1;
    tick();

    // Port-0 write to x5 with same-cycle read on both instances.
    a_if.we_i = 2'b01; a_if.waddr_i = {5'd0, 5'd5}; a_if.wdata_i = {32'h0, 32'hDEADBEEF};
    a_if.raddr_i = {5'd0, 5'd5};
    b_if.we_i = 1'b1; b_if.waddr_i = 5'd5; b_if.wdata_i = 32'hDEADBEEF; b_if.raddr_i = {5'd0, 5'd5};
    #1;
    chk("bypass_x5", 64'(a_if.rdata_o[31:0]), 64'hDEADBEEF);
    chk("nobypass_x5_now", 64'(b_if.rdata_o[31:0]), 64'h0);
    tick();
    a_if.we_i = '0; b_if.we_i = '0;
    #1;
    chk("stored_x5", 64'(a_if.rdata_o[31:0]), 64'hDEADBEEF);
    chk("nobypass_x5_next", 64'(b_if.rdata_o[31:0]), 64'hDEADBEEF);

    // Both ports hit x7: the higher port wins for bypass and storage.
    a_if.we_i = 2'b11; a_if.waddr_i = {5'd7, 5'd7}; a_if.wdata_i = {32'h22, 32'h11};
    a_if.raddr_i = {5'd7, 5'd5};
    #1;
    chk("dual_bypass_x7", 64'(a_if.rdata_o[63:32]), 64'h22);
    tick();
    a_if.we_i = '0;
    #1;
    chk("dual_stored_x7", 64'(a_if.rdata_o[63:32]), 64'h22);

    // Writes to x0 are dropped and x0 always reads zero.
    a_if.we_i = 2'b01; a_if.waddr_i = {5'd0, 5'd0}; a_if.wdata_i = {32'h0, 32'hFF};
    a_if.raddr_i = {5'd7, 5'd0};
    #1;
    chk("x0_bypass", 64'(a_if.rdata_o[31:0]), 64'h0);
    tick();
    a_if.we_i = '0;
    #1;
    chk("x0_stored", 64'(a_if.rdata_o[31:0]), 64'h0);

    // Reservations: x0 never becomes busy, x3 does after one edge.
    a_if.rsv_i = 1'b1; a_if.rsv_addr_i = 5'd0;
    tick();
    a_if.rsv_addr_i = 5'd3;
    #1;
    chk("rsv_x0_ignored", 64'(a_if.busy_o), 64'h0);
    tick();
    a_if.rsv_i = 1'b0; a_if.raddr_i = {5'd7, 5'd3};
    #1;
    chk("rsv_x3_busy", 64'(a_if.busy_o), 64'h8);
    chk("rsv_x3_rbusy", 64'(a_if.rbusy_o[0]), 64'h1);

    // Write plus reserve on x3: data updates, busy stays set.
    a_if.we_i = 2'b01; a_if.waddr_i = {5'd0, 5'd3}; a_if.wdata_i = {32'h0, 32'hABC};
    a_if.rsv_i = 1'b1; a_if.rsv_addr_i = 5'd3;
    tick();
    a_if.we_i = '0; a_if.rsv_i = 1'b0;
    #1;
    chk("rsv_wins_busy", 64'(a_if.busy_o[3]), 64'h1);
    chk("rsv_wins_data", 64'(a_if.rdata_o[31:0]), 64'hABC);

    // Write alone clears busy: rbusy immediately, busy_o after the edge.
    a_if.we_i = 2'b01; a_if.waddr_i = {5'd0, 5'd3}; a_if.wdata_i = {32'h0, 32'hDEF};
    #1;
    chk("clr_rbusy_now", 64'(a_if.rbusy_o[0]), 64'h0);
    chk("clr_busy_o_now", 64'(a_if.busy_o[3]), 64'h1);
    tick();
    a_if.we_i = '0;
    #1;
    chk("clr_busy_o_next", 64'(a_if.busy_o[3]), 64'h0);

    // Debug read of x5 blocked by three cycles of pipeline writes.
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b0; a_if.dbg_addr_i = 5'd5;
    a_if.we_i = 2'b01; a_if.waddr_i = {5'd0, 5'd10}; a_if.wdata_i = {32'h0, 32'h55};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("dbg_blocked_%0d", i), 64'(a_if.dbg_gnt_o), 64'h0);
      tick();
    end
    a_if.we_i = '0;
    #1;
    chk("dbg_gnt_4th", 64'(a_if.dbg_gnt_o), 64'h1);
    chk("dbg_rvalid_pre", 64'(a_if.dbg_rvalid_o), 64'h0);
    tick();
    a_if.dbg_req_i = 1'b0;
    #1;
    chk("dbg_rvalid", 64'(a_if.dbg_rvalid_o), 64'h1);
    chk("dbg_rdata_x5", 64'(a_if.dbg_rdata_o), 64'hDEADBEEF);
    tick();
    chk("dbg_rvalid_one", 64'(a_if.dbg_rvalid_o), 64'h0);

    // Debug write clears a pending reservation on x9.
    a_if.rsv_i = 1'b1; a_if.rsv_addr_i = 5'd9;
    tick();
    a_if.rsv_i = 1'b0;
    #1;
    chk("x9_busy", 64'(a_if.busy_o[9]), 64'h1);
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b1; a_if.dbg_addr_i = 5'd9; a_if.dbg_wdata_i = 32'h1234;
    #1;
    chk("dbgw_gnt", 64'(a_if.dbg_gnt_o), 64'h1);
    tick();
    a_if.dbg_req_i = 1'b0; a_if.raddr_i = {5'd7, 5'd9};
    #1;
    chk("dbgw_data", 64'(a_if.rdata_o[31:0]), 64'h1234);
    chk("dbgw_busy", 64'(a_if.busy_o[9]), 64'h0);
    chk("dbgw_no_rvalid", 64'(a_if.dbg_rvalid_o), 64'h0);

    // Back-to-back debug reads of x7: grants two cycles apart.
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b0; a_if.dbg_addr_i = 5'd7;
    #1;
    chk("b2b_gnt0", 64'(a_if.dbg_gnt_o), 64'h1);
    tick();
    chk("b2b_resp_nogn", 64'(a_if.dbg_gnt_o), 64'h0);
    chk("b2b_rvalid0", 64'(a_if.dbg_rvalid_o), 64'h1);
    chk("b2b_rdata0", 64'(a_if.dbg_rdata_o), 64'h22);
    tick();
    chk("b2b_gnt1", 64'(a_if.dbg_gnt_o), 64'h1);
    chk("b2b_rvalid_gap", 64'(a_if.dbg_rvalid_o), 64'h0);
    tick();
    chk("b2b_rvalid1", 64'(a_if.dbg_rvalid_o), 64'h1);
    a_if.dbg_req_i = 1'b0;

    // Reset mid-traffic while a debug response is pending.
    tick();
    a_if.rsv_i = 1'b1; a_if.rsv_addr_i = 5'd4;
    tick();
    a_if.rsv_i = 1'b0;
    a_if.dbg_req_i = 1'b1; a_if.dbg_addr_i = 5'd5;
    tick();
    a_if.dbg_req_i = 1'b0; a_if.raddr_i = {5'd7, 5'd5};
    #1;
    chk("pre_rst_rvalid", 64'(a_if.dbg_rvalid_o), 64'h1);
    chk("pre_rst_busy", 64'(a_if.busy_o), 64'h10);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(a_if.dbg_rvalid_o), 64'h0);
    chk("mid_rst_busy", 64'(a_if.busy_o), 64'h0);
    chk("mid_rst_rd0", 64'(a_if.rdata_o[31:0]), 64'h0);
    chk("mid_rst_rd1", 64'(a_if.rdata_o[63:32]), 64'h0);
    chk("mid_rst_dbg_rdata", 64'(a_if.dbg_rdata_o), 64'h0);
    tick();
    rstn_i = 1'b1;
    tick();
    chk("post_rst_rvalid", 64'(a_if.dbg_rvalid_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback boundary. It generalises the single-write, two-read register file in depth, read-port count and write-port count, with optional zero register and write-first bypass. It adds a per-register busy scoreboard for in-flight writebacks and a handshaked debug access port. Decode reads operands and busy flags, writeback ports write results, and the debug module reads or writes architectural state between pipeline writes.

## Interface
- XLEN, 32, data width
- DEPTH, 32, number of registers (power of two, >= 2); AW = $clog2(DEPTH)
- NREAD, 2, read ports (1..4)
- NWRITE, 1, write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy clears forwarded
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous, active-low reset
- we_i  in  NWRITE  write enable per port
- waddr_i  in  NWRITE*AW  write address, port w at [w*AW +: AW]
- wdata_i  in  NWRITE*XLEN  write data, packed likewise
- raddr_i  in  NREAD*AW  read addresses
- rdata_o  out  NREAD*XLEN  read data, combinational
- rbusy_o  out  NREAD  busy flag of each read address, combinational
- rsv_i  in  1  reserve: mark rsv_addr_i busy at next edge
- rsv_addr_i  in  AW  register to reserve
- busy_o  out  DEPTH  registered scoreboard vector
- dbg_req_i  in  1  debug request, held until granted
- dbg_we_i  in  1  1 = debug write, 0 = debug read
- dbg_addr_i  in  AW  debug address
- dbg_wdata_i  in  XLEN  debug write data
- dbg_gnt_o  out  1  combinational grant pulse
- dbg_rvalid_o  out  1  registered read-response valid
- dbg_rdata_o  out  XLEN  registered read-response data

## Operation
- Storage: DEPTH x XLEN flops, all cleared on reset.
- Write: at each edge, every port with we_i set writes its data. If several ports hit one address, the highest port index wins. Writes to address 0 are dropped when ZERO_REG=1.
- Read port r, in priority order:
  - 0 if ZERO_REG and raddr is 0.
  - Otherwise, with BYPASS, wdata of the highest-index enabled port whose waddr matches.
  - Otherwise, stored value.
- Scoreboard:
  - Any enabled write clears busy[waddr].
  - rsv_i sets busy[rsv_addr_i].
  - Set and clear of the same address in one cycle: set wins, since it reserves for a newer producer.
  - With ZERO_REG, address 0 is never set.
- rbusy_o[r] = busy[raddr_r]. It is forced 0 when BYPASS and an enabled write targets raddr_r this cycle, or when ZERO_REG and raddr_r is 0.
- Debug FSM with states IDLE and RESP:
  - IDLE: dbg_gnt_o = dbg_req_i & ~|we_i & ~rsv_i. Debug never stalls the pipeline.
  - On grant with dbg_we_i set: write dbg_wdata_i at that edge. It obeys ZERO_REG and clears busy for the address. Stay in IDLE.
  - On grant with dbg_we_i clear: capture the read value using port-read semantics (no bypass possible, since no write is active). Go to RESP.
  - RESP: dbg_rvalid_o = 1 for exactly one cycle, dbg_gnt_o forced 0, then return to IDLE.
- Reset mid-operation: everything returns to reset values immediately. Any pending debug read response is discarded.

## Timing
- Reset values: all registers 0, busy_o = 0, dbg_rvalid_o = 0, dbg_rdata_o = 0, FSM = IDLE.
- Read data and rbusy_o are combinational, with zero latency from address or write inputs.
- Write-to-read latency:
  - 0 cycles with BYPASS.
  - 1 cycle without BYPASS (the value is visible after the edge).
- rsv_i to busy_o: 1 cycle. Clear by write: 1 cycle on busy_o, 0 cycles on rbusy_o with BYPASS.
- Debug write: 1 cycle from grant. Debug read: grant at edge N, dbg_rvalid_o high in cycle N+1. The earliest next grant is cycle N+2.
- Requester may drop dbg_req_i only after the grant edge. Grant is not registered.

## Test plan
- Reset: assert rstn_i mid-traffic -> all rdata_o = 0, busy_o = 0, dbg_rvalid_o = 0 in the same cycle.
- Write port 0 x5 = 0xDEADBEEF, read x5 in the same cycle:
  - BYPASS=1 -> 0xDEADBEEF immediately.
  - BYPASS=0 -> 0 this cycle, 0xDEADBEEF the next.
- Both ports write x7 (port0 = 0x11, port1 = 0x22) -> bypass and stored value both 0x22. Write x0 = 0xFF -> reads 0.
- rsv_i on x3 -> busy_o[3] = 1 next cycle. Port-0 write to x3 plus rsv_i on x3 in the same cycle -> busy stays 1 and data is updated. Write alone -> rbusy_o 0 the same cycle, busy_o[3] = 0 next.
- Debug read of x5 while we_i is high for 3 cycles -> no grant for those 3 cycles. Grant on the 4th cycle, then dbg_rvalid_o = 1 with 0xDEADBEEF one cycle later, for exactly one cycle.
- Debug write x9 = 0x1234 with busy[9] = 1 -> x9 reads 0x1234 and busy[9] = 0 after the edge. Back-to-back debug read requests -> grants at least 2 cycles apart.
